// File: rtl/line_engine_arbiter.sv
// Purpose : two-requester round-robin front end that normalises a line's
//           endpoints and hands them to a single line-draw engine.
// Latency : ack 1 cycle after a request is sampled in IDLE; eng_start 4 cycles
//           after that sample; done 1 cycle after eng_done is sampled in RUN.
// Backpressure: one line at a time; requesters hold req until ack, and any
//           other request waits in place until the block is back in IDLE.
// Ports   : clk, reset (async, active-high);
//           req0/req1 + x0_n,y0_n,x1_n,y1_n in; ack0/ack1, done0/done1 out;
//           eng_x0, eng_y0, eng_dx, eng_dy, eng_steep, eng_ystep_neg, eng_start
//           to the engine; eng_done from the engine; busy = not IDLE.
module line_engine_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic [9:0] x0_0,
  input  logic [9:0] y0_0,
  input  logic [9:0] x1_0,
  input  logic [9:0] y1_0,
  input  logic [9:0] x0_1,
  input  logic [9:0] y0_1,
  input  logic [9:0] x1_1,
  input  logic [9:0] y1_1,
  output logic       ack0,
  output logic       ack1,
  output logic       done0,
  output logic       done1,
  output logic [9:0] eng_x0,
  output logic [9:0] eng_y0,
  output logic [9:0] eng_dx,
  output logic [9:0] eng_dy,
  output logic       eng_steep,
  output logic       eng_ystep_neg,
  output logic       eng_start,
  input  logic       eng_done,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, GRANT, SETUP1, SETUP2, START, RUN, RESP
  } state_t;

  state_t     state;
  logic       last_owner;
  logic       owner;
  logic [9:0] lx0, ly0, lx1, ly1;

  // Arbitration: on a tie the requester that did not win last time gets it.
  logic grant_sel;
  always_comb begin
    grant_sel = req1;
    if (req0 && req1) grant_sel = ~last_owner;
  end

  // SETUP1: steepness from 11-bit signed differences (ties are not steep).
  logic signed [10:0] sdx, sdy;
  logic        [9:0]  adx, ady;
  logic               steep_c;
  always_comb begin
    sdx     = $signed({1'b0, lx1}) - $signed({1'b0, lx0});
    sdy     = $signed({1'b0, ly1}) - $signed({1'b0, ly0});
    adx     = (sdx < 0) ? 10'(-sdx) : 10'(sdx);
    ady     = (sdy < 0) ? 10'(-sdy) : 10'(sdy);
    steep_c = (ady > adx);
  end

  // SETUP2: order endpoints left-to-right, then derive the engine parameters.
  logic               swap_c;
  logic        [9:0]  sx0, sy0, sx1, sy1;
  logic signed [10:0] sdy2;
  logic        [9:0]  ady2;
  always_comb begin
    swap_c = (lx0 > lx1);
    sx0    = swap_c ? lx1 : lx0;
    sy0    = swap_c ? ly1 : ly0;
    sx1    = swap_c ? lx0 : lx1;
    sy1    = swap_c ? ly0 : ly1;
    sdy2   = $signed({1'b0, sy1}) - $signed({1'b0, sy0});
    ady2   = (sdy2 < 0) ? 10'(-sdy2) : 10'(sdy2);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      last_owner    <= 1'b1;
      owner         <= 1'b0;
      lx0           <= '0;
      ly0           <= '0;
      lx1           <= '0;
      ly1           <= '0;
      ack0          <= 1'b0;
      ack1          <= 1'b0;
      done0         <= 1'b0;
      done1         <= 1'b0;
      eng_x0        <= '0;
      eng_y0        <= '0;
      eng_dx        <= '0;
      eng_dy        <= '0;
      eng_steep     <= 1'b0;
      eng_ystep_neg <= 1'b0;
      eng_start     <= 1'b0;
      busy          <= 1'b0;
    end else begin
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      eng_start <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            // Endpoints are captured on entry to GRANT, so they are already
            // held when the requester sees ack and releases its inputs.
            owner      <= grant_sel;
            last_owner <= grant_sel;
            lx0        <= grant_sel ? x0_1 : x0_0;
            ly0        <= grant_sel ? y0_1 : y0_0;
            lx1        <= grant_sel ? x1_1 : x1_0;
            ly1        <= grant_sel ? y1_1 : y1_0;
            ack0       <= ~grant_sel;
            ack1       <= grant_sel;
            busy       <= 1'b1;
            state      <= GRANT;
          end
        end
        GRANT: state <= SETUP1;
        SETUP1: begin
          eng_steep <= steep_c;
          if (steep_c) begin
            lx0 <= ly0;
            ly0 <= lx0;
            lx1 <= ly1;
            ly1 <= lx1;
          end
          state <= SETUP2;
        end
        SETUP2: begin
          eng_x0        <= sx0;
          eng_y0        <= sy0;
          eng_dx        <= sx1 - sx0;
          eng_dy        <= ady2;
          eng_ystep_neg <= (sdy2 < 0);
          eng_start     <= 1'b1;
          state         <= START;
        end
        START: state <= RUN;
        RUN: begin
          if (eng_done) begin
            done0 <= ~owner;
            done1 <= owner;
            state <= RESP;
          end
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_engine_arbiter.sv
// Purpose : directed table-driven bench for line_engine_arbiter, plus
//           hand sequences for the round-robin tie and a mid-line reset.
`timescale 1ns/1ps
module tb_line_engine_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0, req1;
  logic [9:0] x0_0, y0_0, x1_0, y1_0;
  logic [9:0] x0_1, y0_1, x1_1, y1_1;
  logic       ack0, ack1, done0, done1;
  logic [9:0] eng_x0, eng_y0, eng_dx, eng_dy;
  logic       eng_steep, eng_ystep_neg, eng_start;
  logic       eng_done;
  logic       busy;

  always #5 clk = ~clk;

  line_engine_arbiter dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1),
    .x0_0(x0_0), .y0_0(y0_0), .x1_0(x1_0), .y1_0(y1_0),
    .x0_1(x0_1), .y0_1(y0_1), .x1_1(x1_1), .y1_1(y1_1),
    .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
    .eng_x0(eng_x0), .eng_y0(eng_y0), .eng_dx(eng_dx), .eng_dy(eng_dy),
    .eng_steep(eng_steep), .eng_ystep_neg(eng_ystep_neg),
    .eng_start(eng_start), .eng_done(eng_done), .busy(busy)
  );

  typedef struct packed {
    logic       who;
    logic [9:0] x0, y0, x1, y1;
    logic [9:0] ex0, ey0, edx, edy;
    logic       esteep, eneg;
  } vec_t;

  vec_t vecs [8];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic ack_of(input logic who);
    return who ? ack1 : ack0;
  endfunction

  function automatic logic done_of(input logic who);
    return who ? done1 : done0;
  endfunction

  function automatic logic [47:0] all_outs();
    return {ack0, ack1, done0, done1, eng_x0, eng_y0, eng_dx, eng_dy,
            eng_steep, eng_ystep_neg, eng_start, busy};
  endfunction

  task automatic set_coords(input logic who, input logic [9:0] a, b, c, d);
    if (who) begin x0_1 = a; y0_1 = b; x1_1 = c; y1_1 = d; end
    else     begin x0_0 = a; y0_0 = b; x1_0 = c; y1_0 = d; end
  endtask

  task automatic set_req(input logic who, input logic v);
    if (who) req1 = v; else req0 = v;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One complete line; the engine answers eng_done two cycles after it sees
  // eng_start (visible three cycles after eng_start rises).
  task automatic run_line(input int idx, input vec_t v);
    int cyc, t_ack, t_start, t_done, n_ack, n_start, n_other;
    set_coords(v.who, v.x0, v.y0, v.x1, v.y1);
    set_req(v.who, 1'b1);
    cyc = 0; t_ack = -1; t_start = -1; t_done = -1;
    n_ack = 0; n_start = 0; n_other = 0;
    while (t_done < 0 && cyc < 40) begin
      tick();
      cyc++;
      eng_done = 1'b0;
      if (ack_of(v.who)) begin
        n_ack++;
        if (t_ack < 0) t_ack = cyc;
        set_req(v.who, 1'b0);
      end
      if (ack_of(!v.who) || done_of(!v.who)) n_other++;
      if (eng_start) begin
        n_start++;
        if (t_start < 0) begin
          t_start = cyc;
          chk($sformatf("v%0d x0", idx), 64'(eng_x0), 64'(v.ex0));
          chk($sformatf("v%0d y0", idx), 64'(eng_y0), 64'(v.ey0));
          chk($sformatf("v%0d dx", idx), 64'(eng_dx), 64'(v.edx));
          chk($sformatf("v%0d dy", idx), 64'(eng_dy), 64'(v.edy));
          chk($sformatf("v%0d steep", idx), 64'(eng_steep), 64'(v.esteep));
          chk($sformatf("v%0d ystep_neg", idx), 64'(eng_ystep_neg), 64'(v.eneg));
        end
      end
      if (t_start >= 0 && cyc == t_start + 2) eng_done = 1'b1;
      if (done_of(v.who)) begin
        t_done = cyc;
        chk($sformatf("v%0d hold", idx), {eng_x0, eng_y0, eng_dx, eng_dy},
            {v.ex0, v.ey0, v.edx, v.edy});
      end
    end
    set_req(v.who, 1'b0);
    eng_done = 1'b0;
    chk($sformatf("v%0d ack_lat", idx), 64'(t_ack), 64'd1);
    chk($sformatf("v%0d start_lat", idx), 64'(t_start), 64'd4);
    chk($sformatf("v%0d done_lat", idx), 64'(t_done), 64'd7);
    chk($sformatf("v%0d ack_cnt", idx), 64'(n_ack), 64'd1);
    chk($sformatf("v%0d start_cnt", idx), 64'(n_start), 64'd1);
    chk($sformatf("v%0d other", idx), 64'(n_other), 64'd0);
    tick();
    chk($sformatf("v%0d idle", idx), {62'd0, busy, done_of(v.who)}, 64'd0);
  endtask

  initial begin
    int n_ack, n_done, overlap, ts, cyc, t_ack;
    int order [4];
    int dorder [4];

    //        who  x0    y0    x1    y1    ex0   ey0   edx   edy   st   neg
    vecs[0] = '{1'b0, 10'd10, 10'd20, 10'd30, 10'd25, 10'd10, 10'd20, 10'd20, 10'd5, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 10'd5, 10'd100, 10'd8, 10'd40, 10'd40, 10'd8, 10'd60, 10'd3, 1'b1, 1'b1};
    vecs[2] = '{1'b0, 10'd7, 10'd7, 10'd7, 10'd7, 10'd7, 10'd7, 10'd0, 10'd0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 10'd1023, 10'd0, 10'd0, 10'd1023, 10'd0, 10'd1023, 10'd1023, 10'd1023, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 10'd3, 10'd3, 10'd0, 10'd9, 10'd3, 10'd3, 10'd6, 10'd3, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 10'd500, 10'd600, 10'd100, 10'd602, 10'd100, 10'd602, 10'd400, 10'd2, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 10'd0, 10'd0, 10'd5, 10'd5, 10'd0, 10'd0, 10'd5, 10'd5, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 10'd2, 10'd1000, 10'd0, 10'd0, 10'd0, 10'd0, 10'd1000, 10'd2, 1'b1, 1'b0};

    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; eng_done = 1'b0;
    set_coords(1'b0, 10'd0, 10'd0, 10'd0, 10'd0);
    set_coords(1'b1, 10'd0, 10'd0, 10'd0, 10'd0);
    tick(); tick();
    chk("reset outs", 64'(all_outs()), 64'd0);

    // Both requesters raise in the same cycle straight after reset and hold.
    set_coords(1'b0, 10'd1, 10'd2, 10'd3, 10'd4);
    set_coords(1'b1, 10'd100, 10'd200, 10'd50, 10'd60);
    reset = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    n_ack = 0; n_done = 0; overlap = 0; ts = -1; cyc = 0;
    while (cyc < 200 && (n_ack < 4 || busy)) begin
      tick();
      cyc++;
      eng_done = 1'b0;
      if (ack0 && ack1) overlap++;
      if (done0 && done1) overlap++;
      if (ack0 || ack1) begin
        if (n_ack < 4) order[n_ack] = int'(ack1);
        n_ack++;
        if (n_ack == 4) begin req0 = 1'b0; req1 = 1'b0; end
      end
      if (done0 || done1) begin
        if (n_done < 4) dorder[n_done] = int'(done1);
        n_done++;
      end
      if (eng_start) ts = cyc;
      if (ts >= 0 && cyc == ts + 2) eng_done = 1'b1;
    end
    eng_done = 1'b0;
    chk("rr ack count", 64'(n_ack), 64'd4);
    chk("rr done count", 64'(n_done), 64'd4);
    chk("rr overlap", 64'(overlap), 64'd0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rr grant%0d", i), 64'(order[i]), 64'(i % 2));
      chk($sformatf("rr done%0d", i), 64'(dorder[i]), 64'(i % 2));
    end

    for (int i = 0; i < 8; i++) run_line(i, vecs[i]);

    // Reset during RUN with req0 still held, then a late eng_done.
    set_coords(1'b0, 10'd10, 10'd20, 10'd30, 10'd25);
    req0 = 1'b1;
    ts = -1; cyc = 0;
    while (ts < 0 && cyc < 20) begin
      tick();
      cyc++;
      if (eng_start) ts = cyc;
    end
    chk("rst start seen", 64'(ts), 64'd4);
    tick();
    reset = 1'b1;
    #1;
    chk("rst async outs", 64'(all_outs()), 64'd0);
    eng_done = 1'b1;
    tick();
    chk("rst held outs", 64'(all_outs()), 64'd0);
    reset = 1'b0;
    #1;
    chk("rst no early grant", {62'd0, busy, ack0}, 64'd0);
    n_done = 0; t_ack = -1; ts = -1; cyc = 0;
    while (cyc < 20 && !(ts >= 0 && cyc >= ts + 4)) begin
      tick();
      cyc++;
      if (cyc >= 2) eng_done = 1'b0;
      if (ack0 && t_ack < 0) begin t_ack = cyc; req0 = 1'b0; end
      if (done0 || done1) begin
        n_done++;
        chk($sformatf("rst done cyc%0d", cyc), 64'(cyc), 64'(ts + 3));
      end
      if (eng_start) ts = cyc;
      if (ts >= 0 && cyc == ts + 2) eng_done = 1'b1;
    end
    eng_done = 1'b0;
    req0 = 1'b0;
    chk("rst reack", 64'(t_ack), 64'd1);
    chk("rst restart", 64'(ts), 64'd4);
    chk("rst done count", 64'(n_done), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
